player_ctrl: RTL and testbench

- Upstream of the game state machine. Turns debounced player buttons into the lane and jump signals the game FSM and the renderer consume, plus a jump height for sprite placement.
- Lane moves are edge-triggered and clamped to three lanes.
- The jump is a frame-paced rise/hang/fall trajectory.
- While not playing, the jump button level passes straight through so the FSM's start/restart handshake works.

---
 rtl/player_pkg.sv | 40 ++++
 rtl/rise_edge.sv | 33 +++
 rtl/player_ctrl.sv | 131 +++++++++++++
 tb/tb_player_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
// Shared types and constants for the player controller:
//   - jump_state_t : jump trajectory states (GROUND, RISE, HANG, FALL)
//   - LANE_*       : lane encodings (3 is never driven)
//   - HEIGHT_W     : width of the jump height output
//   - next_lane()  : clamped single-step lane move from left/right edges
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package player_pkg;

    localparam int HEIGHT_W = 7;

    localparam logic [1:0] LANE_LEFT   = 2'd0;
    localparam logic [1:0] LANE_CENTRE = 2'd1;
    localparam logic [1:0] LANE_RIGHT  = 2'd2;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        HANG   = 2'd2,
        FALL   = 2'd3
    } jump_state_t;

    // One lane step per edge, clamped at the outer lanes. Both edges in the
    // same cycle cancel out.
    function automatic logic [1:0] next_lane(input logic [1:0] cur,
                                             input logic       left_edge,
                                             input logic       right_edge);
        // NOTE: the result is assigned first on every path, so the function
        // always returns a defined value and callers never infer storage.
        next_lane = cur;
        if (left_edge && !right_edge && cur != LANE_LEFT)
            next_lane = cur - 2'd1;
        else if (right_edge && !left_edge && cur != LANE_RIGHT)
            next_lane = cur + 2'd1;
    endfunction

endpackage

// File: rtl/rise_edge.sv
// -----------------------------------------------------------------------------
// rise_edge
// Rising-edge detector for one debounced button level.
// Ports:
//   clk_in   : system clock
//   rst_in   : asynchronous active-high reset (clears history)
//   level_in : debounced button level
//   edge_out : high for the cycle where level_in is 1 and was 0 last cycle
// The history register updates every cycle; the edge output is combinational.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rise_edge (
    input  logic clk_in,
    input  logic rst_in,
    input  logic level_in,
    output logic edge_out
);

    logic prev_level;

    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: registers use non-blocking assignment so every flop samples
        // its inputs from before the clock edge, independent of block order.
        if (rst_in)
            prev_level <= 1'b0;
        else
            prev_level <= level_in;
    end

    assign edge_out = level_in & ~prev_level;

endmodule

// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
// Turns debounced player buttons into lane position, an airborne flag and a
// jump height for the game FSM and renderer.
// Ports:
//   clk_in     : system clock
//   rst_in     : asynchronous active-high reset
//   frame      : one-cycle pulse per video frame (only time base for jumps)
//   playing    : high while the game is in play
//   reset_game : synchronous clear of lane/jump state for a new game
//   btn_left   : debounced level, lane move on rising edge
//   btn_right  : debounced level, lane move on rising edge
//   btn_jump   : debounced level, jump start on rising edge
//   lane       : 0=left, 1=centre, 2=right (registered)
//   jump       : airborne flag while playing, btn_jump passthrough otherwise
//   height     : jump height above ground (registered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module player_ctrl
    import player_pkg::*;
#(
    parameter int RISE_FRAMES = 16,
    parameter int HANG_FRAMES = 8,
    parameter int RISE_STEP   = 4
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                frame,
    input  logic                playing,
    input  logic                reset_game,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_jump,
    output logic [1:0]          lane,
    output logic                jump,
    output logic [HEIGHT_W-1:0] height
);

    localparam int CNT_MAX = (RISE_FRAMES > HANG_FRAMES) ? RISE_FRAMES : HANG_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter value on the frame that completes each phase.
    localparam logic [CNT_W-1:0]    RISE_LAST = CNT_W'(RISE_FRAMES - 1);
    localparam logic [CNT_W-1:0]    HANG_LAST = CNT_W'(HANG_FRAMES - 1);
    localparam logic [HEIGHT_W-1:0] STEP      = HEIGHT_W'(RISE_STEP);

    logic        left_edge;
    logic        right_edge;
    logic        jump_edge;
    jump_state_t state;
    logic [CNT_W-1:0] cnt;

    rise_edge u_edge_left  (.clk_in(clk_in), .rst_in(rst_in), .level_in(btn_left),  .edge_out(left_edge));
    rise_edge u_edge_right (.clk_in(clk_in), .rst_in(rst_in), .level_in(btn_right), .edge_out(right_edge));
    rise_edge u_edge_jump  (.clk_in(clk_in), .rst_in(rst_in), .level_in(btn_jump),  .edge_out(jump_edge));

    // Lane: moves only in play, holds otherwise, recentred on a new game.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            lane <= LANE_CENTRE;
        else if (reset_game)
            lane <= LANE_CENTRE;
        else if (playing)
            lane <= next_lane(lane, left_edge, right_edge);
    end

    // Jump trajectory, advanced only by frame pulses once airborne.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state  <= GROUND;
            height <= '0;
            cnt    <= '0;
        end else if (reset_game || !playing) begin
            state  <= GROUND;
            height <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                GROUND: begin
                    // Edges outside GROUND are dropped: no double jump, no buffering.
                    if (jump_edge) begin
                        state <= RISE;
                        cnt   <= '0;
                    end
                end
                RISE: begin
                    if (frame) begin
                        height <= height + STEP;
                        if (cnt == RISE_LAST) begin
                            state <= HANG;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HANG: begin
                    if (frame) begin
                        if (cnt == HANG_LAST) begin
                            state <= FALL;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FALL: begin
                    // Land in the same update that brings height to zero.
                    if (frame) begin
                        if (height <= STEP) begin
                            height <= '0;
                            state  <= GROUND;
                        end else begin
                            height <= height - STEP;
                        end
                    end
                end
                default: begin
                    state  <= GROUND;
                    height <= '0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    // Outside play the raw button level drives the FSM's start/restart handshake.
    assign jump = playing ? (state != GROUND) : btn_jump;

endmodule

// File: tb/tb_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_ctrl
// Directed bench for player_ctrl with RISE_FRAMES=3, HANG_FRAMES=2,
// RISE_STEP=4 (peak 12, eight frames airborne).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_player_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       frame;
    logic       playing;
    logic       reset_game;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [1:0] lane;
    logic       jump;
    logic [6:0] height;

    int checks = 0;
    int errors = 0;

    player_ctrl #(
        .RISE_FRAMES(3),
        .HANG_FRAMES(2),
        .RISE_STEP  (4)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .frame     (frame),
        .playing   (playing),
        .reset_game(reset_game),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_jump  (btn_jump),
        .lane      (lane),
        .jump      (jump),
        .height    (height)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_right();
        btn_right = 1'b1; tick();
        btn_right = 1'b0; tick();
    endtask

    task automatic pulse_left();
        btn_left = 1'b1; tick();
        btn_left = 1'b0; tick();
    endtask

    task automatic frame_pulse();
        frame = 1'b1; tick();
        frame = 1'b0;
    endtask

    // Full trajectory: one frame every 10 cycles; optional re-press during HANG.
    task automatic run_jump(input string tag, input bit repress);
        int exp_h [8] = '{4, 8, 12, 12, 12, 8, 4, 0};
        int prev_h;
        btn_jump = 1'b1;
        #1 chk({tag, "_jump_before_edge"}, int'(jump), 0);
        tick();
        chk({tag, "_jump_after_edge"}, int'(jump), 1);
        chk({tag, "_height_at_start"}, int'(height), 0);
        btn_jump = 1'b0;
        prev_h = 0;
        for (int i = 0; i < 8; i++) begin
            repeat (9) tick();
            chk({tag, "_height_idle"}, int'(height), prev_h);
            frame_pulse();
            chk($sformatf("%s_height_f%0d", tag, i + 1), int'(height), exp_h[i]);
            chk($sformatf("%s_jump_f%0d", tag, i + 1), int'(jump), (i < 7) ? 1 : 0);
            prev_h = exp_h[i];
            if (repress && i == 3) begin
                btn_jump = 1'b1; tick();
                btn_jump = 1'b0;
                chk({tag, "_repress_jump"}, int'(jump), 1);
                chk({tag, "_repress_height"}, int'(height), 12);
            end
        end
    endtask

    // Start a jump and climb two frames to height 8.
    task automatic jump_to_8(input string tag);
        btn_jump = 1'b1; tick();
        btn_jump = 1'b0;
        repeat (2) begin
            repeat (3) tick();
            frame_pulse();
        end
        chk({tag, "_height8"}, int'(height), 8);
        chk({tag, "_airborne"}, int'(jump), 1);
    endtask

    initial begin
        rst_in     = 1'b1;
        frame      = 1'b0;
        playing    = 1'b0;
        reset_game = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_jump   = 1'b0;
        #3;
        chk("reset_lane",   int'(lane),   1);
        chk("reset_height", int'(height), 0);
        chk("reset_jump",   int'(jump),   0);
        tick();
        rst_in = 1'b0;
        tick();

        // Lane clamp
        playing = 1'b1;
        pulse_right(); chk("right1", int'(lane), 2);
        pulse_right(); chk("right2", int'(lane), 2);
        pulse_right(); chk("right3", int'(lane), 2);
        pulse_left();  chk("left1",  int'(lane), 1);
        pulse_left();  chk("left2",  int'(lane), 0);
        pulse_left();  chk("left3",  int'(lane), 0);
        pulse_right(); chk("recentre", int'(lane), 1);

        // One-cycle latency from edge to lane
        btn_right = 1'b1;
        #1 chk("lane_before_edge_clk", int'(lane), 1);
        tick();
        chk("lane_after_edge_clk", int'(lane), 2);
        btn_right = 1'b0; tick();
        pulse_left(); chk("back_to_centre", int'(lane), 1);

        // Simultaneous edges, playing and not playing
        btn_left = 1'b1; btn_right = 1'b1; tick();
        chk("both_edges_playing", int'(lane), 1);
        btn_left = 1'b0; btn_right = 1'b0; tick();
        playing = 1'b0;
        btn_left = 1'b1; btn_right = 1'b1; tick();
        chk("both_edges_idle", int'(lane), 1);
        btn_left = 1'b0; btn_right = 1'b0; tick();
        pulse_right(); chk("right_idle_holds", int'(lane), 1);

        // Passthrough while not playing
        btn_jump = 1'b1;
        #1 chk("pass_rise", int'(jump), 1);
        tick();
        chk("pass_hold", int'(jump), 1);
        chk("pass_height", int'(height), 0);
        btn_jump = 1'b0;
        #1 chk("pass_fall", int'(jump), 0);
        tick();
        playing = 1'b1;
        #1 chk("pass_fsm_ground", int'(jump), 0);
        tick();

        // Jump profile, then the same with a re-press during HANG
        run_jump("prof", 1'b0);
        frame_pulse();
        chk("ground_frame_height", int'(height), 0);
        chk("ground_frame_jump", int'(jump), 0);
        run_jump("nodbl", 1'b1);
        chk("lane_after_jumps", int'(lane), 1);

        // Lane changes while airborne
        btn_jump = 1'b1; tick(); btn_jump = 1'b0;
        pulse_left();
        chk("air_lane", int'(lane), 0);
        chk("air_jump", int'(jump), 1);
        playing = 1'b0; tick(); playing = 1'b1; tick();
        pulse_right(); pulse_right();
        chk("lane_right_pre_clear", int'(lane), 2);

        // reset_game mid-rise
        jump_to_8("rg");
        reset_game = 1'b1; tick();
        chk("rg_height", int'(height), 0);
        chk("rg_jump",   int'(jump),   0);
        chk("rg_lane",   int'(lane),   1);
        reset_game = 1'b0; tick();

        // playing dropped mid-rise
        pulse_right();
        jump_to_8("pl");
        playing = 1'b0; tick();
        chk("pl_height", int'(height), 0);
        chk("pl_jump",   int'(jump),   0);
        chk("pl_lane",   int'(lane),   2);
        playing = 1'b1; tick();
        chk("pl_ground", int'(jump), 0);

        // Asynchronous reset mid-cycle
        jump_to_8("ar");
        #3 rst_in = 1'b1;
        #1;
        chk("ar_lane",   int'(lane),   1);
        chk("ar_height", int'(height), 0);
        chk("ar_jump",   int'(jump),   0);
        rst_in = 1'b0;
        tick();
        chk("ar_stays_ground", int'(jump), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
